// File: rtl/ram_stream_loader.sv
// Byte-stream boot loader: assembles big-endian words and writes them sequentially into the Hack RAM.
// Optional checksum trailer enabled by defining RAM_STREAM_LOADER_CHECKSUM_EN.
module ram_stream_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_WORDS = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] ram_address,
  output logic [15:0] ram_in,
  output logic        ram_load,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CSUM_HI, S_CSUM_LO, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] word_q, word_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [15:0] wl_q, wl_d;
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
`endif

  logic        accept;
  logic        writable;
  logic [15:0] idx_inc;
  logic [15:0] rx_word;

  always_comb begin
    rx_ready = (state_q != S_WRITE) && (state_q != S_DONE);
  end

  assign accept   = rx_valid & rx_ready;
  assign writable = {1'b0, idx_q} < MAX_W;
  assign idx_inc  = idx_q + 16'd1;
  // Word completed by the byte on the bus, used in the *_LO states.
  assign rx_word  = {word_q[15:8], rx_data};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    word_d  = word_q;
    addr_d  = addr_q;
    din_d   = din_q;
    busy_d  = busy_q;
    err_d   = err_q;
    wl_d    = wl_q;
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_LEN_HI: if (accept) begin
        len_d[15:8] = rx_data;
        busy_d      = 1'b1;
        err_d       = 1'b0;
        wl_d        = 16'd0;
        idx_d       = 16'd0;
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
        sum_d       = 16'd0;
`endif
        state_d     = S_LEN_LO;
      end
      S_LEN_LO: if (accept) begin
        len_d[7:0] = rx_data;
        if ({len_q[15:8], rx_data} == 16'd0) begin
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
          state_d = S_CSUM_HI;
`else
          busy_d  = 1'b0;
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: if (accept) begin
        word_d[15:8] = rx_data;
        state_d      = S_DATA_LO;
      end
      S_DATA_LO: if (accept) begin
        word_d[7:0] = rx_data;
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
        sum_d       = sum_q + rx_word;
`endif
        // Address/data are staged here so they are stable for the whole WRITE cycle.
        if (writable) begin
          addr_d = BASE_ADDR + idx_q;
          din_d  = rx_word;
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (writable) wl_d = idx_inc;
        else          err_d = 1'b1;
        idx_d = idx_inc;
        if (idx_inc == len_q) begin
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
          state_d = S_CSUM_HI;
`else
          busy_d  = 1'b0;
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA_HI;
        end
      end
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
      S_CSUM_HI: if (accept) begin
        word_d[15:8] = rx_data;
        state_d      = S_CSUM_LO;
      end
      S_CSUM_LO: if (accept) begin
        word_d[7:0] = rx_data;
        if (rx_word != sum_q) err_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_LEN_HI;
      default: state_d = S_LEN_HI;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LEN_HI;
      len_q   <= 16'd0;
      idx_q   <= 16'd0;
      word_q  <= 16'd0;
      addr_q  <= 16'd0;
      din_q   <= 16'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      wl_q    <= 16'd0;
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
      sum_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      wl_q    <= wl_d;
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign ram_load     = (state_q == S_WRITE) && writable;
  assign done         = (state_q == S_DONE);
  assign ram_address  = addr_q;
  assign ram_in       = din_q;
  assign busy         = busy_q;
  assign error        = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_ram_stream_loader.sv
// Bench for ram_stream_loader: a default instance and a small one (MAX_WORDS=2, base 0xFFFF) share one byte stream.
module tb_ram_stream_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic        a_rdy, a_load, a_busy, a_done, a_err;
  logic [15:0] a_addr, a_in, a_wl;
  logic        b_rdy, b_load, b_busy, b_done, b_err;
  logic [15:0] b_addr, b_in, b_wl;

`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  ram_stream_loader dut_a (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(a_rdy),
    .ram_address(a_addr), .ram_in(a_in), .ram_load(a_load), .busy(a_busy), .done(a_done),
    .error(a_err), .words_loaded(a_wl));

  ram_stream_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(2)) dut_b (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(b_rdy),
    .ram_address(b_addr), .ram_in(b_in), .ram_load(b_load), .busy(b_busy), .done(b_done),
    .error(b_err), .words_loaded(b_wl));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;
  wr_t         log_a[$];
  wr_t         log_b[$];
  logic [15:0] wq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write capture (the "RAM") and the no-accept-during-write rule.
  always @(negedge clk) begin
    if (a_load) begin
      log_a.push_back('{a_addr, a_in});
      check("ready_low_in_write_a", {31'd0, a_rdy}, 32'd0);
    end
    if (b_load) begin
      log_b.push_back('{b_addr, b_in});
      check("ready_low_in_write_b", {31'd0, b_rdy}, 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!a_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!a_rdy) begin
      check("rx_ready_timeout", 32'd0, 32'd1);
      return;
    end
    check("ready_match", {31'd0, b_rdy}, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_log(input string tag, input bit is_b, input logic [15:0] base, input int maxw);
    wr_t got[$];
    int  nw;
    if (is_b) got = log_b;
    else      got = log_a;
    nw = (wq.size() < maxw) ? wq.size() : maxw;
    check({tag, "_writes"}, got.size(), nw);
    for (int i = 0; i < nw && i < got.size(); i++) begin
      check({tag, "_addr"}, {16'd0, got[i].a}, {16'd0, 16'(base + 16'(i))});
      check({tag, "_data"}, {16'd0, got[i].d}, {16'd0, wq[i]});
    end
  endtask

  // Sends the stream built from wq, then checks both instances against the reference rules.
  task automatic run_stream(input int gapmax, input bit bad_csum);
    logic [7:0]  bytes[$];
    logic [15:0] n, sum;
    int          t, lat, nexp;
    bit          bad;
    n   = 16'(wq.size());
    sum = 16'd0;
    bytes.push_back(n[15:8]);
    bytes.push_back(n[7:0]);
    foreach (wq[i]) begin
      bytes.push_back(wq[i][15:8]);
      bytes.push_back(wq[i][7:0]);
      sum = sum + wq[i];
    end
    bad = CSUM_EN && bad_csum;
    if (CSUM_EN) begin
      sum = sum + (bad ? 16'd1 : 16'd0);
      bytes.push_back(sum[15:8]);
      bytes.push_back(sum[7:0]);
    end
    log_a.delete();
    log_b.delete();
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i], (gapmax > 0) ? $urandom_range(gapmax, 0) : 0);
      if (i == 0) check("busy_after_len_hi", {31'd0, a_busy}, 32'd1);
    end
    rx_valid = 1'b0;
    t = 0;
    while (!a_done && t < 100) begin
      @(negedge clk);
      t++;
    end
    lat = (CSUM_EN || n == 16'd0) ? 0 : 1;
    check("done_seen", {31'd0, a_done}, 32'd1);
    check("done_latency", t, lat);
    check("done_b", {31'd0, b_done}, 32'd1);
    check("busy_at_done_a", {31'd0, a_busy}, 32'd0);
    check("busy_at_done_b", {31'd0, b_busy}, 32'd0);
    nexp = (wq.size() < 2048) ? wq.size() : 2048;
    check("words_loaded_a", {16'd0, a_wl}, nexp);
    nexp = (wq.size() < 2) ? wq.size() : 2;
    check("words_loaded_b", {16'd0, b_wl}, nexp);
    check("error_a", {31'd0, a_err}, {31'd0, bad});
    check("error_b", {31'd0, b_err}, {31'd0, bad || (wq.size() > 2)});
    check_log("log_a", 1'b0, 16'h0000, 2048);
    check_log("log_b", 1'b1, 16'hFFFF, 2);
    @(negedge clk);
    check("done_one_cycle", {31'd0, a_done}, 32'd0);
    check("ready_after_done", {31'd0, a_rdy}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"}, {16'd0, a_addr}, 32'd0);
    check({tag, "_in"}, {16'd0, a_in}, 32'd0);
    check({tag, "_load"}, {31'd0, a_load}, 32'd0);
    check({tag, "_busy"}, {31'd0, a_busy}, 32'd0);
    check({tag, "_done"}, {31'd0, a_done}, 32'd0);
    check({tag, "_error"}, {31'd0, a_err}, 32'd0);
    check({tag, "_wl"}, {16'd0, a_wl}, 32'd0);
    check({tag, "_ready"}, {31'd0, a_rdy}, 32'd1);
    check({tag, "_b_error"}, {31'd0, b_err}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // 00 03 12 34 AB CD 00 01, valid always high
    wq = '{16'h1234, 16'hABCD, 16'h0001};
    run_stream(0, 1'b0);

    // Empty image
    wq.delete();
    run_stream(0, 1'b0);

    // Random images with random source stalls
    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(6, 1);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
      run_stream(3, 1'b0);
    end

    // Reset after 1.5 words of a 4-word load
    wq = '{16'hBEEF, 16'h0102, 16'h0304, 16'h0506};
    log_a.delete();
    log_b.delete();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_byte(8'hBE, 1);
    send_byte(8'hEF, 0);
    send_byte(8'h01, 0);
    rx_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check_reset_vals("midload_reset");
    check("midload_writes", log_a.size(), 1);
    if (log_a.size() > 0) begin
      check("midload_word0_addr", {16'd0, log_a[0].a}, 32'd0);
      check("midload_word0_data", {16'd0, log_a[0].d}, 32'h0000BEEF);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_stream(2, 1'b0);

`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
    wq = '{16'h0001, 16'h0002};
    run_stream(0, 1'b0);
    run_stream(0, 1'b1);
    wq.delete();
    run_stream(1, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_stream_loader.md
Name: ram_stream_loader

Overview:
- Byte-stream boot loader that sits directly upstream of the 2048-word Hack data/instruction RAM.
- Accepts bytes over a valid/ready handshake, typically from a UART receiver.
- Assembles big-endian 16-bit words and writes them sequentially into RAM through the RAM's address/in/load write port.
- Holds the CPU off (`busy`) while an image is being loaded.

Parameters:
- BASE_ADDR, 0, first RAM word address written.
- MAX_WORDS, 2048, maximum words written; words beyond this are consumed but not written.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte this cycle.
- ram_address  output  16  RAM word address (RAM decodes [10:0]).
- ram_in  output  16  word to write.
- ram_load  output  1  RAM write enable, one-cycle pulse per word.
- busy  output  1  load in progress; hold the CPU in reset while high.
- done  output  1  one-cycle pulse when an image completes.
- error  output  1  sticky: overflow (or checksum mismatch when that feature is compiled in).
- words_loaded  output  16  number of words actually written by the last/current load.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values:
  - State LEN_HI.
  - ram_address=0, ram_in=0, ram_load=0, busy=0, done=0, error=0, words_loaded=0.
  - Internal count, index and word registers cleared.
- Byte acceptance: a byte is accepted on a rising edge where rx_valid&rx_ready. rx_ready is decoded from state: 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO; 0 in WRITE and DONE.
- Stream format: length word N (hi byte, lo byte), then N data words (hi byte first), then optionally a checksum.
- State transitions:
  - LEN_HI: on accept, store N[15:8], set busy=1, clear error and words_loaded. -> LEN_LO.
  - LEN_LO: on accept, store N[7:0]. If N==0 -> DONE, else -> DATA_HI.
  - DATA_HI: on accept, store word[15:8]. -> DATA_LO.
  - DATA_LO: on accept, store word[7:0]. -> WRITE.
  - WRITE, exactly one cycle:
    - If idx<MAX_WORDS: ram_load=1, ram_address=(BASE_ADDR+idx) mod 2^16, ram_in=word, words_loaded=idx+1.
    - Else: ram_load=0 and error=1.
    - Then idx++. If idx==N, go to DONE (or CSUM_HI when the checksum feature is compiled in), else DATA_HI.
  - DONE: done=1 for one cycle, busy=0. -> LEN_HI.
- Latency: last byte accepted -> ram_load high on the next cycle -> done one cycle later.
- Output timing: ram_load is low in every state except WRITE. ram_address and ram_in hold their last values otherwise.
- Boundaries:
  - Source stalls (rx_valid=0) are allowed in any receiving state; no timeout.
  - Bytes presented during WRITE/DONE are not accepted; the source must hold them.
  - N=0xFFFF with MAX_WORDS=2048: 2048 writes, 63487 words discarded, error=1.
  - Address wraps modulo 2^16.
- Reset mid-load: immediate return to reset state. Words already written remain in RAM; there is no partial done.

Optional Feature:
- Macro: RAM_STREAM_LOADER_CHECKSUM_EN.
- With the macro:
  - After the last data word, states CSUM_HI/CSUM_LO accept a 16-bit checksum, then go to DONE.
  - The expected checksum is the mod-2^16 sum of all N data words, including discarded ones.
  - On mismatch, error=1 in the same cycle done pulses.
  - With N=0 the checksum is still expected and must equal 0.
- Without the macro: no checksum states; DONE follows the final WRITE.

Test Plan:
- Reset, then stream 00 03 12 34 AB CD 00 01 with rx_valid always high -> three ram_load pulses: addr 0/0x1234, 1/0xABCD, 2/0x0001. Then done pulse, busy falls, words_loaded=3, error=0.
- Stream 00 00 -> no ram_load, done one cycle after the second byte, words_loaded=0.
- MAX_WORDS=2, stream 00 03 + 3 words -> only addr 0,1 written, error=1, words_loaded=2, done asserted.
- Random rx_valid gaps plus rx_valid held high during WRITE -> no byte lost or duplicated. RAM contents match a reference model, and rx_ready=0 on each WRITE cycle.
- Assert reset after 1.5 words of a 4-word load -> all outputs return to reset values immediately. Word 0 remains in RAM, and a subsequent clean load succeeds.
- With RAM_STREAM_LOADER_CHECKSUM_EN:
  - Stream 00 02 00 01 00 02 00 03 -> error=0.
  - Same stream with checksum 00 04 -> error=1 at done.
